// File: rtl/mix_matrix_seq_if.sv
// Handshake bundle for mix_matrix_seq: input state, MixColumns result, flush and busy.
// The master side drives state and control; the slave side is the MixColumns engine.
interface mix_matrix_seq_if;
   logic [3:0][31:0] In_DI;
   logic             InValid_SI;
   logic             InReady_SO;
   logic [3:0][31:0] Out_DO;
   logic             OutValid_SO;
   logic             OutReady_SI;
   logic             Flush_SI;
   logic             Busy_SO;

   modport master (
      output In_DI, InValid_SI, OutReady_SI, Flush_SI,
      input  InReady_SO, Out_DO, OutValid_SO, Busy_SO
   );

   modport slave (
      input  In_DI, InValid_SI, OutReady_SI, Flush_SI,
      output InReady_SO, Out_DO, OutValid_SO, Busy_SO
   );
endinterface

// File: rtl/mix_matrix_seq.sv
// Column-serial AES MixColumns engine: COLS_PER_CYCLE shared mixColumn lanes sweep the four columns.
// Optional macro MIX_MATRIX_SEQ_BACK2BACK_EN lets DONE hand over straight to the next accepted state.
module mix_matrix_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic            Clk_CI,
   input  logic            Reset_RBI,
   mix_matrix_seq_if.slave bus
);

   typedef logic [3:0][31:0] matrix_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [1:0] COL_STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_COL_CNT = 2'(4 - COLS_PER_CYCLE);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
         $error("mix_matrix_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte 0 of a column sits in bits [31:24].
   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] b0, b1, b2, b3;
      b0 = c[31:24];
      b1 = c[23:16];
      b2 = c[15:8];
      b3 = c[7:0];
      return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
              b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
              b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
              xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
   endfunction

   state_e      r_state;
   state_e      w_state_nxt;
   logic [1:0]  r_col_cnt;
   matrix_t     r_state_reg;
   matrix_t     r_out_reg;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_last;
   logic [31:0] w_lane_out [COLS_PER_CYCLE];

   for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
      localparam logic [1:0] LANE = 2'(i);
      logic [1:0] w_col_idx;
      assign w_col_idx     = r_col_cnt + LANE;
      assign w_lane_out[i] = mix_column(r_state_reg[w_col_idx]);
   end

   assign w_last   = (r_col_cnt == LAST_COL_CNT);
   assign w_accept = bus.InValid_SI && w_in_ready && !bus.Flush_SI;

   // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (w_accept) w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
`ifdef MIX_MATRIX_SEQ_BACK2BACK_EN
            w_in_ready = bus.OutReady_SI;
            if (bus.OutReady_SI) w_state_nxt = w_accept ? S_BUSY : S_IDLE;
`else
            if (bus.OutReady_SI) w_state_nxt = S_IDLE;
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (bus.Flush_SI) w_state_nxt = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of process order.
   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   // NOTE: the wide state/output registers are reset on purpose, because Out_DO has a defined reset value of zero.
   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         r_state_reg <= '0;
         r_out_reg   <= '0;
         r_col_cnt   <= '0;
      end else begin
         if (w_accept) r_state_reg <= bus.In_DI;

         if (bus.Flush_SI || w_accept) r_col_cnt <= '0;
         else if (r_state == S_BUSY)   r_col_cnt <= w_last ? 2'd0 : r_col_cnt + COL_STEP;

         if (r_state == S_BUSY && !bus.Flush_SI) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
               r_out_reg[r_col_cnt + 2'(k)] <= w_lane_out[k];
            end
         end
      end
   end

   assign bus.InReady_SO  = w_in_ready;
   assign bus.Out_DO      = r_out_reg;
   assign bus.OutValid_SO = (r_state == S_DONE);
   assign bus.Busy_SO     = (r_state == S_BUSY);

endmodule

// File: tb/tb_mix_matrix_seq.sv
// Bench for mix_matrix_seq: three instances (1, 2, 4 columns per cycle) share one stimulus stream;
// each has a negedge monitor that pops a model-filled queue on every output handshake.
`timescale 1ns/1ps
module tb_mix_matrix_seq;

   localparam int N = 3;

`ifdef MIX_MATRIX_SEQ_BACK2BACK_EN
   localparam int STREAM_GAP = 5;
`else
   localparam int STREAM_GAP = 6;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0][31:0] r_in;
   logic             r_in_valid;
   logic [N-1:0]     r_valid_en;
   logic             r_out_ready;
   logic             r_flush;

   logic [127:0]     w_out [N];
   logic [N-1:0]     w_out_valid;
   logic [N-1:0]     w_in_ready;
   logic [N-1:0]     w_busy;
   logic [N-1:0]     w_in_valid;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int pending [N];
   int hs_total [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Generic GF(2^8) shift-and-add multiply, modulus 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [3:0][31:0] m);
      logic [7:0]       base [4];
      logic [3:0][31:0] res;
      logic [7:0]       acc;
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++) acc = acc ^ gmul(base[(c - r) & 3], m[k][31 - 8*c -: 8]);
            res[k][31 - 8*r -: 8] = acc;
         end
      end
      return res;
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int LAT = 4 >> g;

      mix_matrix_seq_if u_if ();

      assign w_in_valid[g]     = r_in_valid & r_valid_en[g];
      assign u_if.In_DI        = r_in;
      assign u_if.InValid_SI   = w_in_valid[g];
      assign u_if.OutReady_SI  = r_out_ready;
      assign u_if.Flush_SI     = r_flush;
      assign w_out[g]          = u_if.Out_DO;
      assign w_out_valid[g]    = u_if.OutValid_SO;
      assign w_in_ready[g]     = u_if.InReady_SO;
      assign w_busy[g]         = u_if.Busy_SO;

      mix_matrix_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .Clk_CI    (clk),
         .Reset_RBI (rst_n),
         .bus       (u_if.slave)
      );

      logic [127:0] exp_q [$];
      logic         waiting;
      int           acc_edge;
      int           busy_cnt;

      initial begin
         waiting     = 1'b0;
         acc_edge    = 0;
         busy_cnt    = 0;
         pending[g]  = 0;
         hs_total[g] = 0;
         forever begin
            @(negedge clk);
            if (!rst_n || r_flush) begin
               exp_q.delete();
               waiting = 1'b0;
            end else begin
               if (waiting) begin
                  if (w_busy[g]) busy_cnt++;
                  if (w_out_valid[g]) begin
                     check($sformatf("latency[%0d]", g), 128'(cyc - acc_edge), 128'(LAT));
                     check($sformatf("busy_cycles[%0d]", g), 128'(busy_cnt), 128'(LAT));
                     waiting = 1'b0;
                  end
               end
               if (w_out_valid[g] && !r_out_ready) begin
                  check($sformatf("stall_in_ready[%0d]", g), 128'(w_in_ready[g]), 128'(0));
                  if (exp_q.size() > 0) check($sformatf("stall_hold[%0d]", g), w_out[g], exp_q[0]);
                  else                  check($sformatf("stall_unexpected[%0d]", g), 128'(1), 128'(0));
               end
               if (w_out_valid[g] && r_out_ready) begin
                  hs_total[g]++;
                  if (exp_q.size() > 0) check($sformatf("out[%0d]", g), w_out[g], exp_q.pop_front());
                  else                  check($sformatf("out_unexpected[%0d]", g), 128'(1), 128'(0));
               end
               if (w_in_valid[g] && w_in_ready[g]) begin
                  exp_q.push_back(model(r_in));
                  waiting  = 1'b1;
                  acc_edge = cyc + 1;
                  busy_cnt = 0;
               end
            end
            pending[g] = exp_q.size();
         end
      end
   end

   function automatic logic all_drained();
      logic ok;
      ok = (&w_in_ready) && (w_out_valid == '0);
      for (int g = 0; g < N; g++) if (pending[g] != 0) ok = 1'b0;
      return ok;
   endfunction

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (t < 200 && !all_drained()) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check({tag, "_drain_timeout"}, 128'(1), 128'(0));
   endtask

   task automatic send(input logic [127:0] m);
      int t;
      t = 0;
      while (t < 100 && !(&(w_in_ready | ~r_valid_en))) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) check("send_timeout", 128'(1), 128'(0));
      r_in       = m;
      r_in_valid = 1'b1;
      @(posedge clk); #1;
      r_in_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      for (int g = 0; g < N; g++) begin
         check($sformatf("%s_out[%0d]", tag, g), w_out[g], 128'(0));
         check($sformatf("%s_ctl[%0d]", tag, g),
               128'({w_out_valid[g], w_busy[g], w_in_ready[g]}), 128'(3'b001));
      end
   endtask

   logic [3:0][31:0] vec_a;
   logic [3:0][31:0] vec_b;
   logic [3:0][31:0] rnd;
   int               hs_before [N];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_a[0] = 32'hdb135345; vec_a[1] = 32'hf20a225c; vec_a[2] = 32'h01010101; vec_a[3] = 32'hc6c6c6c6;
      vec_b[0] = 32'hd4d4d4d5; vec_b[1] = 32'h2d26314c; vec_b[2] = 32'h00000000; vec_b[3] = 32'hffffffff;

      rst_n       = 1'b0;
      r_in        = '0;
      r_in_valid  = 1'b0;
      r_valid_en  = '1;
      r_out_ready = 1'b1;
      r_flush     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer vector on all three lane widths; also checked against the published result.
      send(vec_a);
      drain("single");
      for (int g = 0; g < N; g++)
         check($sformatf("kat_a[%0d]", g), w_out[g],
               {32'hc6c6c6c6, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc});

      // Backpressure: result must hold while the sink stalls.
      for (int g = 0; g < N; g++) hs_before[g] = hs_total[g];
      r_out_ready = 1'b0;
      send(vec_b);
      repeat (10) begin @(posedge clk); #1; end
      r_out_ready = 1'b1;
      drain("backpressure");
      for (int g = 0; g < N; g++) begin
         check($sformatf("bp_handshakes[%0d]", g), 128'(hs_total[g] - hs_before[g]), 128'(1));
         check($sformatf("kat_b[%0d]", g), w_out[g],
               {32'hffffffff, 32'h00000000, 32'h4d7ebdf8, 32'hd5d5d7d6});
      end

      // Flush two cycles into BUSY, with a competing input offer.
      send(vec_a);
      @(posedge clk); #1;
      @(posedge clk); #1;
      r_flush    = 1'b1;
      r_in       = vec_b;
      r_in_valid = 1'b1;
      @(posedge clk); #1;
      r_flush    = 1'b0;
      r_in_valid = 1'b0;
      for (int g = 0; g < N; g++)
         check($sformatf("flush_ctl[%0d]", g),
               128'({w_out_valid[g], w_busy[g], w_in_ready[g]}), 128'(3'b001));
      repeat (3) begin @(posedge clk); #1; end
      for (int g = 0; g < N; g++) check($sformatf("flush_no_capture[%0d]", g), 128'(w_busy[g]), 128'(0));
      send(vec_b);
      drain("after_flush");

      // Asynchronous reset between edges while BUSY.
      send(vec_a);
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(vec_b);
      drain("after_reset");

      // Random vectors with a randomly stalling sink.
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < 4; k++) rnd[k] = $urandom;
         send(rnd);
         repeat ($urandom_range(0, 6)) begin
            r_out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         r_out_ready = 1'b1;
         drain("random");
      end

      // Streaming on the single-lane instance: accept spacing and in-order results.
      r_valid_en = 3'b001;
      begin
         int  k;
         int  prev;
         int  guard;
         logic acc;
         k     = 0;
         prev  = 0;
         guard = 0;
         for (int j = 0; j < 4; j++) rnd[j] = $urandom;
         r_in       = rnd;
         r_in_valid = 1'b1;
         while (k < 8 && guard < 500) begin
            acc = w_in_ready[0];
            @(posedge clk); #1;
            guard++;
            if (acc) begin
               if (k > 0) check($sformatf("stream_gap[%0d]", k), 128'(cyc - prev), 128'(STREAM_GAP));
               prev = cyc;
               k++;
               for (int j = 0; j < 4; j++) rnd[j] = $urandom;
               r_in = rnd;
            end
         end
         r_in_valid = 1'b0;
         if (k < 8) check("stream_timeout", 128'(k), 128'(8));
      end
      drain("stream");
      r_valid_en = '1;

      for (int g = 0; g < N; g++) check($sformatf("leftover[%0d]", g), 128'(pending[g]), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mix_matrix_seq.md
Name: mix_matrix_seq

Overview:
- Column-serial MixColumns engine for the AES-128 round datapath.
- Time-shares COLS_PER_CYCLE mixColumn instances across the four 32-bit columns of a Matrix-typed state.
- Uses valid/ready handshakes on input and output, so it can replace the fully parallel mixMatrix in area-constrained round implementations.
- Sits between the ShiftRows output and the AddRoundKey input.

Parameters:
- COLS_PER_CYCLE, 1, number of mixColumn instances and columns processed per cycle; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
- Clk_CI  input  1  clock; all state updates on rising edge.
- Reset_RBI  input  1  asynchronous, active-low reset.
- In_DI  input  Matrix (128)  input state; column k is In_DI[k].
- InValid_SI  input  1  In_DI valid.
- InReady_SO  output  1  block can accept In_DI.
- Out_DO  output  Matrix (128)  MixColumns result.
- OutValid_SO  output  1  Out_DO valid.
- OutReady_SI  input  1  downstream accepts Out_DO.
- Flush_SI  input  1  synchronous abort; returns block to IDLE.
- Busy_SO  output  1  high in BUSY state.

Behaviour:
- Clocking and reset: single clock Clk_CI; Reset_RBI is asynchronous, active-low.
- Reset values: state IDLE, column counter 0, input register 0, Out_DO 0, OutValid_SO 0, Busy_SO 0, InReady_SO 1.
- Registers:
  - StateReg (128): captured input.
  - OutReg (128): drives Out_DO directly; no combinational path from In_DI to Out_DO.
  - ColCnt: 2 bits; counts in steps of COLS_PER_CYCLE.
- FSM IDLE:
  - InReady_SO = 1.
  - On InValid_SI && InReady_SO: capture In_DI into StateReg, set ColCnt = 0, go to BUSY.
- FSM BUSY:
  - InReady_SO = 0, Busy_SO = 1.
  - Each cycle: columns ColCnt .. ColCnt+COLS_PER_CYCLE-1 of StateReg pass through the shared mixColumn instances. Results are written to the same column indices of OutReg. ColCnt += COLS_PER_CYCLE.
  - On the cycle that writes column 3: go to DONE; ColCnt wraps to 0.
- FSM DONE:
  - OutValid_SO = 1; Out_DO holds stable while OutValid_SO && !OutReady_SI.
  - On OutReady_SI: go to IDLE; OutValid_SO drops on the next edge.
- Latency: OutValid_SO rises 4/COLS_PER_CYCLE clock edges after the accepting edge (4, 2 or 1).
- Throughput without the optional feature: one state per 4/COLS_PER_CYCLE + 2 cycles (accept cycle + BUSY cycles + output cycle).
- Partial OutReg: columns not yet written during BUSY keep their previous values. Out_DO is only meaningful while OutValid_SO = 1.
- InValid_SI outside IDLE: ignored; no capture, no error.
- Flush_SI:
  - In any state: next state IDLE, ColCnt 0, OutValid_SO 0; OutReg and StateReg contents are left unchanged.
  - Flush_SI has priority over an input accept and over an output handshake in the same cycle. A state offered with InValid_SI in that cycle is not captured.
- Reset asserted mid-operation: immediate return to reset values; the in-flight state is lost.
- Arithmetic: entirely inside mixColumn (GF(2^8) with polynomial 0x11B). This block adds no arithmetic of its own beyond ColCnt.

Optional Feature:
- Macro: MIX_MATRIX_SEQ_BACK2BACK_EN.
- Defined:
  - In DONE, InReady_SO = OutReady_SI.
  - If OutReady_SI && InValid_SI in the same cycle: the output is consumed, In_DI is captured, and the next state is BUSY directly (IDLE skipped).
  - Sustained throughput becomes one state per 4/COLS_PER_CYCLE + 1 cycles.
  - InReady_SO is then combinationally dependent on OutReady_SI.
- Undefined:
  - InReady_SO is high only in IDLE.
  - All outputs are registered or decoded from state only; no input-to-output combinational path.

Test Plan:
- Reset and single transfer: release reset, COLS_PER_CYCLE=1, hold OutReady_SI=1, drive In_DI columns {db135345, f20a225c, 01010101, c6c6c6c6} with InValid_SI=1 for one cycle.
  - Expect Out_DO = {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}.
  - OutValid_SO rises exactly 4 edges after the accept edge; Busy_SO high for 4 cycles.
- Parameter sweep: same vector with COLS_PER_CYCLE=2 and 4 -> same Out_DO, latency 2 and 1 edges respectively.
- Backpressure: columns {d4d4d4d5, 2d26314c, 00000000, ffffffff}, OutReady_SI=0 for 10 cycles, then 1.
  - Expect Out_DO = {d5d5d7d6, 4d7ebdf8, 00000000, ffffffff}, stable throughout the stall.
  - InReady_SO=0 during the stall; exactly one output handshake.
- Flush mid-BUSY: assert Flush_SI at ColCnt=2 together with InValid_SI=1.
  - Next cycle: IDLE, OutValid_SO=0, no capture.
  - A subsequent transfer produces the correct result.
- Async reset mid-BUSY: pull Reset_RBI low between clock edges -> outputs take reset values immediately, without waiting for a clock edge.
- Back-to-back (macro defined): 8 states streamed with OutReady_SI=1 and InValid_SI=1.
  - Input accepts are spaced 5 cycles apart at COLS_PER_CYCLE=1.
  - All 8 results match the reference model, in order.
